// File: rtl/mem_access_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access.sv
// Memory-stage load/store engine: runs one req/ack bus transaction per load or
// store, aligns/extends load data and emits one writeback pulse per bundle.
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               load_en,
   input  logic               store_en,
   input  logic               write_reg,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        data,
   input  logic [31:0]        res,
   input  logic [4:0]         rd,
   mem_access_if.master       bus,
   output logic               wb_valid,
   output logic               wb_en,
   output logic [4:0]         wb_rd,
   output logic [31:0]        wb_data,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUS} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       funct3_p1;
   logic [1:0]       off_p1;
   logic [4:0]       rd_p1;
   logic             write_reg_p1;

   logic is_mem;
   logic illegal;
   logic misaligned;

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = rdata[8*a +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  return 32'(b);
         3'b001:  return 32'(h);
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return rdata;
      endcase
   endfunction

   assign in_ready = (state == IDLE);

   always_comb begin
      is_mem     = load_en | store_en;
      illegal    = (load_en & store_en)
                 | (load_en  & !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                 | (store_en & !(funct3 inside {3'b000, 3'b001, 3'b010}));
      misaligned = ((funct3[1:0] == 2'b01) & addr[0])
                 | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         funct3_p1     <= '0;
         off_p1        <= '0;
         rd_p1         <= '0;
         write_reg_p1  <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         wb_valid      <= 1'b0;
         wb_en         <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         err           <= 1'b0;
         err_code      <= 2'b00;
      end else begin
         wb_valid <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  wb_rd <= rd;
                  if (!is_mem) begin
                     wb_valid <= 1'b1;
                     wb_en    <= write_reg;
                     wb_data  <= res;
                     err_code <= 2'b00;
                  end else if (illegal || misaligned) begin
                     // Faults retire immediately without touching the bus
                     wb_valid <= 1'b1;
                     wb_en    <= 1'b0;
                     wb_data  <= '0;
                     err      <= 1'b1;
                     err_code <= illegal ? 2'b11 : 2'b01;
                  end else begin
                     state         <= BUS;
                     cnt           <= '0;
                     funct3_p1     <= funct3;
                     off_p1        <= addr[1:0];
                     rd_p1         <= rd;
                     write_reg_p1  <= write_reg;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= store_en;
                     bus.mem_addr  <= {addr[31:2], 2'b00};
                     bus.mem_wdata <= store_lanes(funct3, data);
                     bus.mem_wstrb <= store_en ? store_strb(funct3, addr[1:0]) : 4'b0000;
                  end
               end
            end
            BUS: begin
               // Ack in the final allowed cycle still counts as completion
               if (bus.mem_ack) begin
                  state       <= IDLE;
                  bus.mem_req <= 1'b0;
                  wb_valid    <= 1'b1;
                  wb_rd       <= rd_p1;
                  err_code    <= 2'b00;
                  wb_en       <= !bus.mem_we & write_reg_p1;
                  wb_data     <= bus.mem_we ? 32'd0
                                            : load_extract(funct3_p1, off_p1, bus.mem_rdata);
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state       <= IDLE;
                  bus.mem_req <= 1'b0;
                  wb_valid    <= 1'b1;
                  wb_rd       <= rd_p1;
                  wb_en       <= 1'b0;
                  wb_data     <= '0;
                  err         <= 1'b1;
                  err_code    <= 2'b10;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written corner sequences
// and randomized bundles checked against a byte-level reference model.
module tb_mem_access;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        load_en = 1'b0, store_en = 1'b0, write_reg = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, data = '0, res = '0;
   logic [4:0]  rd = '0;
   logic        wb_valid, wb_en, err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  err_code;

   mem_access_if bus();

   mem_access #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .load_en(load_en), .store_en(store_en), .write_reg(write_reg),
      .funct3(funct3), .addr(addr), .data(data), .res(res), .rd(rd),
      .bus(bus), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          load, store, wreg;
      logic [2:0]  f3;
      logic [31:0] addr, data, res;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          delay;
   } op_t;

   typedef struct {
      int          req;
      bit          we;
      logic [31:0] maddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      bit          wb_en;
      logic [4:0]  rd;
      logic [31:0] wb_data;
      bit          err;
      logic [1:0]  code;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t e;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic op_t mk_op(bit ld, bit st, bit wr, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] d, logic [31:0] r, logic [4:0] dst,
                                 logic [31:0] rdat, int dly);
      op_t o;
      o.load = ld; o.store = st; o.wreg = wr; o.f3 = f3; o.addr = a; o.data = d;
      o.res = r; o.rd = dst; o.rdata = rdat; o.delay = dly;
      return o;
   endfunction

   function automatic exp_t mk_exp(int rq, bit we, logic [31:0] ma, logic [3:0] ws,
                                   logic [31:0] wd, bit en, logic [4:0] dst,
                                   logic [31:0] wbd, bit er, logic [1:0] cd);
      exp_t e;
      e.req = rq; e.we = we; e.maddr = ma; e.wstrb = ws; e.wdata = wd; e.wb_en = en;
      e.rd = dst; e.wb_data = wbd; e.err = er; e.code = cd;
      return e;
   endfunction

   // Reference model: byte-size arithmetic, not the RTL's lane tables
   function automatic exp_t model(op_t op);
      exp_t   e;
      int     size, off;
      bit     legal, tmo;
      longint v, mask;
      e = mk_exp(0, 0, 0, 0, 0, 0, op.rd, 0, 0, 0);
      if (!op.load && !op.store) begin
         e.wb_en = op.wreg; e.wb_data = op.res;
         return e;
      end
      legal = !(op.load && op.store) &&
              (op.load ? (int'(op.f3) inside {0, 1, 2, 4, 5}) : (int'(op.f3) inside {0, 1, 2}));
      if (!legal) begin e.err = 1; e.code = 2'd3; return e; end
      size = 1 << int'(op.f3 % 4);
      off  = int'(op.addr % 4);
      if (off % size != 0) begin e.err = 1; e.code = 2'd1; return e; end
      tmo = (op.delay < 0) || (op.delay >= TIMEOUT);
      e.req   = tmo ? TIMEOUT : op.delay + 1;
      e.we    = op.store;
      e.maddr = op.addr - 32'(off);
      if (op.store) begin
         for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = op.data[8*(i % size) +: 8];
         e.wstrb = 4'(((1 << size) - 1) << off);
      end
      if (tmo) begin e.err = 1; e.code = 2'd2; return e; end
      if (op.load) begin
         mask = (longint'(1) << (8 * size)) - 1;
         v = longint'(op.rdata >> (8 * off)) & mask;
         if (op.f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
         e.wb_en = op.wreg;
         e.wb_data = v[31:0];
      end
      return e;
   endfunction

   // Entered and left at posedge+1; acts as the bus slave while mem_req is high
   task automatic do_op(input op_t op, input exp_t e);
      int w = 0;
      int n = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      chk("in_ready_before", in_ready, 1);
      load_en = op.load; store_en = op.store; write_reg = op.wreg; funct3 = op.f3;
      addr = op.addr; data = op.data; res = op.res; rd = op.rd; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
      addr = $urandom; data = $urandom; res = $urandom;
      while (bus.mem_req && n < 40) begin
         chk("mem_we", bus.mem_we, e.we);
         chk("mem_addr", bus.mem_addr, e.maddr);
         chk("mem_wstrb", bus.mem_wstrb, e.wstrb);
         if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
         chk("in_ready_busy", in_ready, 0);
         chk("wb_valid_busy", wb_valid, 0);
         if (n == op.delay) begin bus.mem_ack = 1'b1; bus.mem_rdata = op.rdata; end
         @(posedge clk); #1;
         bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
         n++;
      end
      chk("req_cycles", n, e.req);
      chk("wb_valid", wb_valid, 1);
      chk("err", err, e.err);
      if (e.err) chk("err_code", err_code, e.code);
      chk("wb_en", wb_en, e.wb_en);
      if (e.wb_en) begin
         chk("wb_rd", wb_rd, e.rd);
         chk("wb_data", wb_data, e.wb_data);
      end
      chk("in_ready_after", in_ready, 1);
      @(posedge clk); #1;
      chk("wb_valid_pulse", wb_valid, 0);
      chk("err_pulse", err, 0);
   endtask

   vec_t tbl[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t  op;
      int   kind, r;

      tbl[0]  = '{mk_op(1,0,1,3'b000,32'h203,0,0,5'd7,32'h80FF1234,2),
                  mk_exp(3,0,32'h200,4'b0000,0,1,5'd7,32'hFFFFFF80,0,2'b00)};
      tbl[1]  = '{mk_op(1,0,1,3'b101,32'h302,0,0,5'd8,32'hBEEF0000,0),
                  mk_exp(1,0,32'h300,4'b0000,0,1,5'd8,32'h0000BEEF,0,2'b00)};
      tbl[2]  = '{mk_op(0,1,1,3'b001,32'h302,32'h1234ABCD,0,5'd9,0,1),
                  mk_exp(2,1,32'h300,4'b1100,32'hABCDABCD,0,5'd9,0,0,2'b00)};
      tbl[3]  = '{mk_op(1,0,1,3'b010,32'h101,0,0,5'd4,0,0),
                  mk_exp(0,0,0,0,0,0,5'd4,0,1,2'b01)};
      tbl[4]  = '{mk_op(1,1,1,3'b010,32'h100,0,0,5'd4,0,0),
                  mk_exp(0,0,0,0,0,0,5'd4,0,1,2'b11)};
      tbl[5]  = '{mk_op(1,0,1,3'b010,32'h400,0,0,5'd2,32'h11111111,-1),
                  mk_exp(16,0,32'h400,4'b0000,0,0,5'd2,0,1,2'b10)};
      tbl[6]  = '{mk_op(1,0,1,3'b010,32'h400,0,0,5'd3,32'hCAFEF00D,15),
                  mk_exp(16,0,32'h400,4'b0000,0,1,5'd3,32'hCAFEF00D,0,2'b00)};
      tbl[7]  = '{mk_op(0,1,0,3'b000,32'h201,32'h00000055,0,5'd1,0,0),
                  mk_exp(1,1,32'h200,4'b0010,32'h55555555,0,5'd1,0,0,2'b00)};
      tbl[8]  = '{mk_op(1,0,1,3'b011,32'h0,0,0,5'd6,0,0),
                  mk_exp(0,0,0,0,0,0,5'd6,0,1,2'b11)};
      tbl[9]  = '{mk_op(0,1,0,3'b100,32'h0,0,0,5'd6,0,0),
                  mk_exp(0,0,0,0,0,0,5'd6,0,1,2'b11)};
      tbl[10] = '{mk_op(1,0,1,3'b001,32'h206,0,0,5'd10,32'h80011234,3),
                  mk_exp(4,0,32'h204,4'b0000,0,1,5'd10,32'hFFFF8001,0,2'b00)};
      tbl[11] = '{mk_op(0,0,0,3'b000,32'h0,0,32'h1234,5'd9,0,0),
                  mk_exp(0,0,0,0,0,0,5'd9,0,0,2'b00)};
      tbl[12] = '{mk_op(0,1,0,3'b010,32'h10C,32'hDEADBEEF,0,5'd0,0,0),
                  mk_exp(1,1,32'h10C,4'b1111,32'hDEADBEEF,0,5'd0,0,0,2'b00)};
      tbl[13] = '{mk_op(1,0,1,3'b100,32'h201,0,0,5'd11,32'h00009A00,0),
                  mk_exp(1,0,32'h200,4'b0000,0,1,5'd11,32'h0000009A,0,2'b00)};
      tbl[14] = '{mk_op(0,0,1,3'b000,32'h0,0,32'hA5A5,5'd31,0,0),
                  mk_exp(0,0,0,0,0,1,5'd31,32'hA5A5,0,2'b00)};
      tbl[15] = '{mk_op(0,1,0,3'b001,32'h203,32'h5555,0,5'd2,0,0),
                  mk_exp(0,0,0,0,0,0,5'd2,0,1,2'b01)};

      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_wstrb", bus.mem_wstrb, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) do_op(tbl[i].op, tbl[i].e);

      // Three back-to-back ALU bundles
      write_reg = 1'b1; rd = 5'd5; in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         res = 32'(i);
         @(posedge clk); #1;
         chk("b2b_wb_valid", wb_valid, 1);
         chk("b2b_wb_data", wb_data, 32'(i));
         chk("b2b_wb_rd", wb_rd, 5);
         chk("b2b_in_ready", in_ready, 1);
         chk("b2b_mem_req", bus.mem_req, 0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_end", wb_valid, 0);

      // Stray ack while idle
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      chk("idle_ack_req", bus.mem_req, 0);
      chk("idle_ack_wb", wb_valid, 0);
      chk("idle_ack_ready", in_ready, 1);

      // Reset in the second BUS cycle of a store
      load_en = 1'b0; store_en = 1'b1; funct3 = 3'b010; addr = 32'h100;
      data = 32'h12345678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; store_en = 1'b0;
      chk("rstbus_req1", bus.mem_req, 1);
      @(posedge clk); #1;
      chk("rstbus_req2", bus.mem_req, 1);
      rst = 1'b0; #1;
      chk("rstbus_req_drop", bus.mem_req, 0);
      chk("rstbus_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      chk("rstbus_no_wb", wb_valid, 0);
      @(posedge clk); #1;
      chk("rstbus_no_wb2", wb_valid, 0);
      chk("rstbus_ready2", in_ready, 1);
      chk("rstbus_req_idle", bus.mem_req, 0);

      // Randomized bundles against the model
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 9);
         op.load  = (kind >= 2 && kind <= 5) || kind == 9;
         op.store = (kind >= 6);
         op.wreg  = 1'($urandom);
         op.f3    = 3'($urandom_range(0, 7));
         op.addr  = $urandom;
         op.data  = $urandom;
         op.res   = $urandom;
         op.rd    = 5'($urandom);
         op.rdata = $urandom;
         r = $urandom_range(0, 9);
         op.delay = (r == 0) ? -1 : (r == 1) ? $urandom_range(14, 17) : $urandom_range(0, 6);
         do_op(op, model(op));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store engine sitting directly after the execute stage. It consumes the execute stage's result bundle (load_en, store_en, addr, data, write_reg, res), runs a req/ack transaction on the data-memory bus for loads and stores, and aligns and extends load data. It presents a single writeback pulse per accepted instruction and back-pressures execute while a bus transaction is outstanding.

## Interface
Parameters:
- TIMEOUT, 16, number of BUS-state cycles allowed without mem_ack before the transaction is aborted (must be ≥2).

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  execute bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- load_en  input  1  instruction is a load
- store_en  input  1  instruction is a store
- write_reg  input  1  instruction writes rd
- funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  input  32  byte address of the access
- data  input  32  store data (low bytes significant)
- res  input  32  ALU result for non-memory instructions
- rd  input  5  destination register
- mem_req  output  1  bus request, held until ack
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  {addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables (0000 on reads)
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  transaction complete
- wb_valid  output  1  one-cycle writeback pulse
- wb_en  output  1  write wb_data to wb_rd
- wb_rd  output  5  destination register
- wb_data  output  32  writeback value
- err  output  1  one-cycle fault pulse, coincident with wb_valid
- err_code  output  2  01 misaligned, 10 bus timeout, 11 illegal (funct3 invalid or load_en&store_en)

## Operation
- States: IDLE, BUS. in_ready = (state == IDLE); accept = in_valid & in_ready.
- IDLE, accept, no memory op: next cycle wb_valid=1, wb_en=write_reg, wb_data=res, wb_rd=rd; stay IDLE.
- IDLE, accept, illegal (funct3 ∉ {000,001,010,100,101} for loads, ∉ {000,001,010} for stores, or both enables): next cycle wb_valid=1, wb_en=0, err=1, err_code=11; no bus activity.
- IDLE, accept, misaligned (H with addr[0]=1, W with addr[1:0]≠0): same as illegal but err_code=01.
- IDLE, accept, legal aligned access: latch addr, funct3, rd, write_reg, data; go BUS; mem_req=1 from next cycle.
- BUS: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb held stable until mem_ack sampled high. On ack: go IDLE, mem_req low next cycle, wb_valid=1 next cycle. Loads: wb_en=write_reg, wb_data=extracted value. Stores: wb_en=0.
- Store lanes (a = addr[1:0]): SB wstrb=0001<<a, wdata={4{data[7:0]}}; SH wstrb=0011<<a, wdata={2{data[15:0]}}; SW wstrb=1111, wdata=data.
- Load extract: B/BU take byte a of mem_rdata, H/HU take halfword addr[1]; sign-extend for B/H, zero-extend for BU/HU; W passes through.
- Timeout: cycle counter cleared on BUS entry, increments each BUS cycle without ack. On the TIMEOUT-th BUS cycle without ack: drop mem_req, go IDLE, next cycle wb_valid=1, wb_en=0, err=1, err_code=10. mem_ack in that same cycle wins (normal completion).
- mem_ack while IDLE is ignored.

## Timing
- Reset (rst low, asynchronous): state IDLE, in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, err=0, err_code=00. Reset in BUS abandons the transaction immediately; no writeback is produced.
- Non-memory and faulting instructions: accept at T, wb_valid at T+1; one per cycle back-to-back.
- Memory access with ack k cycles after request (k≥0): accept T, mem_req high T+1..T+1+k, ack sampled T+1+k, wb_valid and in_ready high at T+2+k; a new bundle may be accepted at T+2+k.
- wb_valid, err are single-cycle pulses; wb_en/wb_rd/wb_data only meaningful with wb_valid.

## Test plan
- Reset mid-transaction: SW addr 0x100, hold ack low, assert rst at BUS cycle 2 -> mem_req drops same cycle, no wb_valid, in_ready=1 after release.
- ALU passthrough: three back-to-back bundles res=1,2,3, write_reg=1, rd=5 -> wb_valid three consecutive cycles, wb_data 1,2,3, no mem_req.
- LB sign: addr 0x203, funct3 000, ack after 2 cycles with mem_rdata 0x80FF_1234 -> mem_addr 0x200, wb_data 0xFFFF_FF80, wb_valid at T+4.
- LHU / SH lanes: LHU addr 0x302, rdata 0xBEEF_0000 -> wb_data 0x0000_BEEF; SH addr 0x302 data 0x1234_ABCD -> wstrb 1100, wdata 0xABCD_ABCD, wb_en=0.
- Misaligned/illegal: LW addr 0x101 -> err=1 code 01, no mem_req; load_en=store_en=1 -> err code 11.
- Timeout: TIMEOUT=16, LW addr 0x400, ack never -> mem_req high 16 cycles, then err code 10, wb_en=0; repeat with ack on 16th cycle -> normal wb, no err.
